// File: rtl/x2_actmon_pkg.sv
// Shared types and constants for the x2 activity monitor.
package x2_actmon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StReport
    } state_t;

    localparam int unsigned NUM_OUT   = 7;
    localparam logic [2:0]  TOTAL_IDX = 3'd7;

endpackage

// File: rtl/x2_popcnt7.sv
// Combinational population count of a 7-bit vector.
module x2_popcnt7 (
    input  logic [6:0] vec,
    output logic [2:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, vec[i]};
        end
    end

endmodule

// File: rtl/x2_activity_monitor.sv
// Toggle-activity monitor over a window of samples from the x2 logic stage.
// Define X2_ACTMON_PERBIT_EN for per-bit counts; otherwise only the total is reported.
module x2_activity_monitor
    import x2_actmon_pkg::*;
#(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned SMP_W = $clog2(WINDOW + 1);
`ifdef X2_ACTMON_PERBIT_EN
    localparam logic [2:0] FIRST_IDX = 3'd0;
`else
    localparam logic [2:0] FIRST_IDX = TOTAL_IDX;
`endif

    state_t               state_q, state_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [NUM_OUT-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [2:0]           idx_q, idx_d;
    logic [NUM_OUT-1:0]   diff;
    logic [2:0]           diff_cnt;
    logic [CNT_W+2:0]     total_sum;
    logic                 accept;
    logic                 win_open;

    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q != StIdle);
    assign accept    = in_valid && in_ready;
    assign win_open  = (state_q == StIdle) && start;
    assign diff      = in_vec ^ ref_q;
    assign total_sum = {3'b000, total_q} + {{CNT_W{1'b0}}, diff_cnt};

    x2_popcnt7 u_popcnt (
        .vec (diff),
        .cnt (diff_cnt)
    );

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        ref_d   = ref_q;
        total_d = total_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    smp_d   = '0;
                    ref_d   = '0;
                    total_d = '0;
                end
            end
            StAccum: begin
                if (accept) begin
                    ref_d = in_vec;
                    smp_d = smp_q + SMP_W'(1);
                    // First sample of the window only seeds the reference.
                    if (smp_q != '0) begin
                        total_d = (|total_sum[CNT_W+2:CNT_W]) ? '1 : total_sum[CNT_W-1:0];
                    end
                    if (smp_q == SMP_W'(WINDOW - 1)) begin
                        state_d = StReport;
                        idx_d   = FIRST_IDX;
                    end
                end
            end
            StReport: begin
                if (out_ready) begin
                    if (idx_q == TOTAL_IDX) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d = StIdle;
            smp_d   = '0;
            ref_d   = '0;
            total_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            smp_q   <= '0;
            ref_q   <= '0;
            total_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            ref_q   <= ref_d;
            total_q <= total_d;
            idx_q   <= idx_d;
        end
    end

`ifdef X2_ACTMON_PERBIT_EN
    logic [CNT_W-1:0] bit_cnt_q [NUM_OUT];
    logic [CNT_W-1:0] bit_cnt_d [NUM_OUT];

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clr || win_open) begin
            for (int i = 0; i < NUM_OUT; i++) bit_cnt_d[i] = '0;
        end else if (accept && (smp_q != '0)) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (diff[i] && (bit_cnt_q[i] != '1)) begin
                    bit_cnt_d[i] = bit_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) bit_cnt_q[i] <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end
`endif

    // Outputs are gated by state so reset zeroes them without a clock edge.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        if (state_q == StReport) begin
            out_valid = 1'b1;
            out_idx   = idx_q;
            out_last  = (idx_q == TOTAL_IDX);
            out_data  = total_q;
`ifdef X2_ACTMON_PERBIT_EN
            if (idx_q != TOTAL_IDX) out_data = bit_cnt_q[idx_q];
`endif
        end
    end

endmodule

// File: tb/tb_x2_activity_monitor.sv
// Scoreboard bench: two instances (WINDOW=4/CNT_W=16 and WINDOW=8/CNT_W=2) share the stimulus.
module tb_x2_activity_monitor;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       start = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [6:0] in_vec = '0;

    logic        a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [15:0] a_out_data;
    logic [2:0]  a_out_idx;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [1:0]  b_out_data;
    logic [2:0]  b_out_idx;

    x2_activity_monitor #(.WINDOW(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start && !sel),
        .clr       (clr && !sel),
        .in_valid  (in_valid && !sel),
        .in_ready  (a_in_ready),
        .in_vec    (in_vec),
        .out_valid (a_out_valid),
        .out_ready (out_ready && !sel),
        .out_data  (a_out_data),
        .out_idx   (a_out_idx),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    x2_activity_monitor #(.WINDOW(8), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start && sel),
        .clr       (clr && sel),
        .in_valid  (in_valid && sel),
        .in_ready  (b_in_ready),
        .in_vec    (in_vec),
        .out_valid (b_out_valid),
        .out_ready (out_ready && sel),
        .out_data  (b_out_data),
        .out_idx   (b_out_idx),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    wire        obs_ready = sel ? b_in_ready  : a_in_ready;
    wire        obs_valid = sel ? b_out_valid : a_out_valid;
    wire        obs_last  = sel ? b_out_last  : a_out_last;
    wire        obs_busy  = sel ? b_busy      : a_busy;
    wire [2:0]  obs_idx   = sel ? b_out_idx   : a_out_idx;
    wire [15:0] obs_data  = sel ? {14'b0, b_out_data} : a_out_data;

    int         checks = 0;
    int         errors = 0;
    beat_t      sb[$];
    logic [6:0] stim[$];

`ifdef X2_ACTMON_PERBIT_EN
    localparam logic [2:0] FIRST_IDX = 3'd0;
    localparam logic [2:0] STALL_IDX = 3'd2;
`else
    localparam logic [2:0] FIRST_IDX = 3'd7;
    localparam logic [2:0] STALL_IDX = 3'd7;
`endif

    // Reference model: expected report beats for the samples in stim.
    task automatic push_model(input int cw);
        int         per[7];
        int         tot;
        int         mx;
        logic [6:0] x;
        mx  = (1 << cw) - 1;
        tot = 0;
        for (int k = 0; k < 7; k++) per[k] = 0;
        for (int s = 1; s < stim.size(); s++) begin
            x = stim[s] ^ stim[s-1];
            for (int k = 0; k < 7; k++) if (x[k] && per[k] < mx) per[k]++;
            tot = tot + $countones(x);
            if (tot > mx) tot = mx;
        end
`ifdef X2_ACTMON_PERBIT_EN
        for (int k = 0; k < 7; k++) sb.push_back('{3'(k), 16'(per[k]), 1'b0});
`endif
        sb.push_back('{3'd7, 16'(tot), 1'b1});
    endtask

    task automatic send_window();
        int w;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        foreach (stim[i]) begin
            w = 0;
            while (obs_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            checks++;
            if (obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_wait sample %0d got %b want 1", i, obs_ready);
            end
            in_valid = 1'b1;
            in_vec   = stim[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic [2:0] stall_idx, input int stall_n);
        int    budget;
        int    left;
        beat_t e;
        budget = 0;
        left   = stall_n;
        while (sb.size() > 0 && budget < 100) begin
            budget++;
            out_ready = 1'b0;
            if (obs_valid === 1'b1) begin
                e = sb[0];
                checks++;
                if (obs_idx !== e.idx || obs_data !== e.data || obs_last !== e.last) begin
                    errors++;
                    $display("FAIL beat got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                             obs_idx, obs_data, obs_last, e.idx, e.data, e.last);
                end
                if (e.idx == stall_idx && left > 0) left--;
                else begin
                    out_ready = 1'b1;
                    void'(sb.pop_front());
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL report_timeout got %0d beats left want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_report got busy=%b valid=%b want 0 0", obs_busy, obs_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_last, a_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {a_in_ready, a_out_valid, a_out_last, a_busy});
        end
        checks++;
        if (a_out_idx !== 3'd0 || a_out_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got idx=%0d data=%0d want 0 0", a_out_idx, a_out_data);
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_out_last, b_busy, b_out_idx, b_out_data} !== 9'b0) begin
            errors++;
            $display("FAIL reset_sat got %b want 0", {b_out_valid, b_busy, b_out_idx, b_out_data});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_toggle_all();
        stim = '{7'h00, 7'h7F, 7'h00, 7'h7F};
        push_model(16);
        send_window();
        drain(3'd0, 0);
    endtask

    task automatic test_sparse();
        stim = '{7'h01, 7'h01, 7'h03, 7'h02};
        push_model(16);
        send_window();
        drain(3'd0, 0);
    endtask

    task automatic test_backpressure();
        stim = '{7'h15, 7'h6A, 7'h33, 7'h4C};
        push_model(16);
        send_window();
        drain(STALL_IDX, 5);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            stim.delete();
            for (int i = 0; i < 4; i++) stim.push_back(7'($urandom_range(0, 127)));
            push_model(16);
            send_window();
            drain(3'd0, 0);
        end
    endtask

    task automatic test_saturate();
        sel  = 1'b1;
        stim = '{7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F};
        push_model(2);
        send_window();
        drain(3'd0, 0);
        sel = 1'b0;
    endtask

    task automatic test_clr();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_vec = 7'h12;
        @(negedge clk); in_vec = 7'h55;
        @(negedge clk); in_valid = 1'b0; clr = 1'b1; start = 1'b1;
        @(negedge clk); clr = 1'b0; start = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle got busy=%b valid=%b ready=%b want 0 0 0",
                     a_busy, a_out_valid, a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_start got busy=%b want 0", a_busy);
        end
        stim = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        push_model(16);
        send_window();
        drain(3'd0, 0);
    endtask

    task automatic test_reset_in_report();
        stim = '{7'h0F, 7'h70, 7'h0F, 7'h70};
        send_window();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_idx !== FIRST_IDX) begin
            errors++;
            $display("FAIL start_in_report got valid=%b idx=%0d want 1 %0d",
                     a_out_valid, a_out_idx, FIRST_IDX);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_last, a_busy} !== 4'b0 ||
            a_out_idx !== 3'd0 || a_out_data !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got flags=%b idx=%0d data=%0d want 0 0 0",
                     {a_in_ready, a_out_valid, a_out_last, a_busy}, a_out_idx, a_out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", a_busy, a_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_toggle_all();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_saturate();
        test_clr();
        test_reset_in_report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
